// File: rtl/alu_result_serializer_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_serializer_pkg
//   Shared types for the ALU result serializer: serializer FSM state
//   encoding, ALU unit identifiers in priority order, and the helpers used to
//   pick the winning unit and to detect simultaneous result flags.
//   No ports (package).
// ---------------------------------------------------------------------------
package alu_result_serializer_pkg;

    // Serializer FSM: waiting for a word, or streaming bytes of one word.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Unit identifiers double as bit positions in the packed flag vector.
    // A lower value means a higher priority: arith > logic > cmp > shift.
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'd0,
        UNIT_LOGIC = 2'd1,
        UNIT_CMP   = 2'd2,
        UNIT_SHIFT = 2'd3
    } unit_t;

    localparam int NUM_UNITS = 4;

    // Highest-priority unit with its flag set. With no flag set the result is
    // irrelevant because nothing is pushed.
    function automatic unit_t pick_unit(input logic [NUM_UNITS-1:0] flags);
        if (flags[UNIT_ARITH])      return UNIT_ARITH;
        else if (flags[UNIT_LOGIC]) return UNIT_LOGIC;
        else if (flags[UNIT_CMP])   return UNIT_CMP;
        else                        return UNIT_SHIFT;
    endfunction

    // True when two or more flags are set (clearing the lowest set bit
    // leaves something behind).
    function automatic logic multi_hot(input logic [NUM_UNITS-1:0] flags);
        return (flags & (flags - NUM_UNITS'(1))) != '0;
    endfunction

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Synchronous FIFO holding ALU result words waiting to be serialized.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset (pointers only)
//   push   - write request, wdata is written when accepted
//   wdata  - word to write
//   pop    - read request, ignored while empty
//   rdata  - head word (valid while not empty)
//   full   - DEPTH words stored
//   empty  - no words stored
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
//   Collects results from four ALU units, keeps the highest-priority one per
//   cycle in a small FIFO and streams each word to a UART transmitter as
//   WIDTH/8 bytes, least-significant byte first, with a valid/ready handshake.
// Ports:
//   clk, rst                    - clock (rising edge), async active-low reset
//   arith/logic/cmp/shift_out   - unit result words
//   arith/logic/cmp/shift_flag  - unit result-valid pulses
//   tx_data, tx_valid, tx_ready - byte stream toward the transmitter
//   busy                        - words queued or a word being sent
//   overflow                    - sticky: a result was dropped (FIFO full)
//   multi_flag_err              - sticky: several flags in one cycle
// ---------------------------------------------------------------------------
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0] logic_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             overflow,
    output logic             multi_flag_err
);

    localparam int NUM_BYTES = WIDTH / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    logic [NUM_UNITS-1:0] flags;
    logic                 push_req;
    logic [WIDTH-1:0]     push_data;
    logic                 pop;
    logic                 dropped;
    logic [WIDTH-1:0]     fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    state_t               state;
    logic [WIDTH-1:0]     shift_reg;
    logic [CNT_W-1:0]     byte_cnt;

    // Bit positions follow the unit_t encoding.
    assign flags    = {shift_flag, cmp_flag, logic_flag, arith_flag};
    assign push_req = |flags;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_data = '0;
        case (pick_unit(flags))
            UNIT_ARITH: push_data = arith_out;
            UNIT_LOGIC: push_data = logic_out;
            UNIT_CMP:   push_data = cmp_out;
            UNIT_SHIFT: push_data = shift_out;
            default:    push_data = '0;
        endcase
    end

    // Only IDLE pops, so the final byte of a word never overlaps a pop.
    assign pop     = (state == IDLE) && !fifo_empty;
    assign dropped = push_req && fifo_full && !pop;

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= fifo_rdata;
                        byte_cnt  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // tx_valid is high throughout SEND, so tx_ready alone
                    // completes the handshake.
                    if (tx_ready) begin
                        shift_reg <= shift_reg >> 8;
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                        if (byte_cnt == LAST_BYTE) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow       <= 1'b0;
            multi_flag_err <= 1'b0;
        end else begin
            if (dropped)          overflow       <= 1'b1;
            if (multi_hot(flags)) multi_flag_err <= 1'b1;
        end
    end

    // Outputs come straight from flops; tx_data stays put while stalled
    // because the shift register only moves on a handshake.
    assign tx_valid = (state == SEND);
    assign tx_data  = shift_reg[7:0];
    assign busy     = !fifo_empty || (state == SEND);

endmodule

// File: tb/tb_alu_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_serializer
//   Directed scenarios plus a randomized run, all compared every cycle with a
//   queue-based reference model of the result path and the byte stream.
// ---------------------------------------------------------------------------
module tb_alu_result_serializer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int NB    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
    logic             arith_flag = 1'b0, logic_flag = 1'b0;
    logic             cmp_flag = 1'b0, shift_flag = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             busy;
    logic             overflow;
    logic             multi_flag_err;

    alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .arith_out      (arith_out),
        .logic_out      (logic_out),
        .cmp_out        (cmp_out),
        .shift_out      (shift_out),
        .arith_flag     (arith_flag),
        .logic_flag     (logic_flag),
        .cmp_flag       (cmp_flag),
        .shift_flag     (shift_flag),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .overflow       (overflow),
        .multi_flag_err (multi_flag_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Words waiting, the word being sent and how many of its bytes have gone.
    logic [WIDTH-1:0] m_q[$];
    bit               m_active;
    logic [WIDTH-1:0] m_word;
    int               m_sent;
    bit               m_ovf;
    bit               m_multi;
    logic [7:0]       got_bytes[$];

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_word   = '0;
        m_sent   = 0;
        m_ovf    = 0;
        m_multi  = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs seen before the edge.
    task automatic model_edge(input logic [3:0] f, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] c,
                              input logic [WIDTH-1:0] s, input logic rdy);
        bit               take;
        int               n;
        logic [WIDTH-1:0] w;
        take = !m_active && (m_q.size() > 0);
        if (m_active && rdy) begin
            m_sent++;
            if (m_sent == NB) m_active = 0;
        end
        if (take) begin
            m_word   = m_q.pop_front();
            m_sent   = 0;
            m_active = 1;
        end
        n = $countones(f);
        if (n >= 2) m_multi = 1;
        if (n >= 1) begin
            w = f[0] ? a : f[1] ? l : f[2] ? c : s;
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else                    m_ovf = 1;
        end
    endtask

    task automatic compare_model();
        logic [7:0] eb;
        check("tx_valid", tx_valid, m_active);
        if (m_active) begin
            eb = m_word[8*m_sent +: 8];
            check("tx_data", tx_data, eb);
        end
        check("busy", busy, m_active || (m_q.size() != 0));
        check("overflow", overflow, m_ovf);
        check("multi_flag_err", multi_flag_err, m_multi);
    endtask

    // Advance one clock: log a handshake, step the model, compare after edge.
    task automatic cycle();
        logic [3:0]       f;
        logic [WIDTH-1:0] a, l, c, s;
        logic             rdy;
        f   = {shift_flag, cmp_flag, logic_flag, arith_flag};
        a   = arith_out; l = logic_out; c = cmp_out; s = shift_out;
        rdy = tx_ready;
        if (rst && tx_valid && tx_ready) got_bytes.push_back(tx_data);
        @(posedge clk);
        model_edge(f, a, l, c, s, rdy);
        #1;
        compare_model();
    endtask

    task automatic clear_flags();
        arith_flag = 0; logic_flag = 0; cmp_flag = 0; shift_flag = 0;
    endtask

    task automatic push_arith(input logic [WIDTH-1:0] w);
        arith_out  = w;
        arith_flag = 1;
        cycle();
        clear_flags();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_multi", multi_flag_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        got_bytes.delete();
    endtask

    task automatic drain(input int max_cycles);
        tx_ready = 1;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (!busy) break;
        end
        check("drain_timeout", busy, 1'b0);
    endtask

    task automatic expect_words(input string tag, input logic [WIDTH-1:0] w[$]);
        check({tag, "_count"}, got_bytes.size(), w.size() * NB);
        if (got_bytes.size() == w.size() * NB) begin
            for (int i = 0; i < w.size(); i++)
                for (int b = 0; b < NB; b++)
                    check(tag, got_bytes[i*NB + b], w[i][8*b +: 8]);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp_w[$];
        bit               found;

        #2;
        // ---- reset values and basic LSB-first transfer with latency ----
        reset_pulse();
        tx_ready   = 1;
        arith_out  = 16'hBEEF;
        arith_flag = 1;
        cycle();                 // edge N: word pushed
        clear_flags();
        check("beef_valid_n", tx_valid, 1'b0);
        cycle();                 // edge N+1: popped
        check("beef_valid_n1", tx_valid, 1'b1);
        check("beef_byte0", tx_data, 8'hEF);
        cycle();
        check("beef_valid_n2", tx_valid, 1'b1);
        check("beef_byte1", tx_data, 8'hBE);
        cycle();
        check("beef_valid_end", tx_valid, 1'b0);
        check("beef_busy_end", busy, 1'b0);

        // ---- two flags at once: priority winner only ----
        reset_pulse();
        tx_ready   = 1;
        logic_out  = 16'h00F0;
        shift_out  = 16'h1234;
        logic_flag = 1;
        shift_flag = 1;
        cycle();
        clear_flags();
        drain(20);
        exp_w = '{16'h00F0};
        expect_words("multi_bytes", exp_w);
        check("multi_err", multi_flag_err, 1'b1);

        // ---- stall and overflow: 6 pushes, one latched, 4 queued, 1 dropped ----
        reset_pulse();
        tx_ready = 0;
        for (int i = 0; i < 6; i++) push_arith(16'h1100 + 16'(i * 16'h0111));
        check("ovf_set", overflow, 1'b1);
        check("ovf_head_byte", tx_data, 8'h00);
        check("ovf_valid", tx_valid, 1'b1);
        drain(40);
        exp_w = '{16'h1100, 16'h1211, 16'h1322, 16'h1433, 16'h1544};
        expect_words("ovf_order", exp_w);

        // ---- ready toggling 1,0,0,1 during A55A ----
        reset_pulse();
        tx_ready = 1;
        push_arith(16'hA55A);
        cycle();                 // pop cycle, ready high but no valid yet
        tx_ready = 0;
        cycle();
        check("stall_data0", tx_data, 8'h5A);
        cycle();
        check("stall_data1", tx_data, 8'h5A);
        check("stall_valid", tx_valid, 1'b1);
        tx_ready = 1;
        cycle();
        check("stall_next", tx_data, 8'hA5);
        cycle();
        check("stall_done", tx_valid, 1'b0);
        exp_w = '{16'hA55A};
        expect_words("stall_bytes", exp_w);

        // ---- reset in the middle of a word with two queued ----
        reset_pulse();
        tx_ready = 0;
        push_arith(16'h1357);
        push_arith(16'h2468);
        push_arith(16'h9ABC);
        tx_ready = 1;
        cycle();                 // first byte 0x57 accepted
        check("mid_byte1", tx_data, 8'h13);
        reset_pulse();
        tx_ready = 1;
        repeat (8) cycle();
        check("after_rst_silent", got_bytes.size(), 0);
        push_arith(16'h4321);
        drain(20);
        exp_w = '{16'h4321};
        expect_words("after_rst_word", exp_w);

        // ---- full FIFO, FSM in IDLE, push in the pop cycle ----
        reset_pulse();
        tx_ready = 0;
        for (int i = 0; i < 5; i++) push_arith(16'h7000 + 16'(i));
        tx_ready = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!m_active && m_q.size() == DEPTH) begin
                found      = 1;
                shift_out  = 16'h5555;
                shift_flag = 1;
                cycle();
                clear_flags();
            end else begin
                cycle();
            end
        end
        check("full_idle_reached", found, 1'b1);
        check("full_pop_push_ovf", overflow, 1'b0);
        drain(40);
        exp_w = '{16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h5555};
        expect_words("full_pop_push", exp_w);

        // ---- randomized traffic against the model ----
        reset_pulse();
        for (int i = 0; i < 2000; i++) begin
            arith_out  = WIDTH'($urandom);
            logic_out  = WIDTH'($urandom);
            cmp_out    = WIDTH'($urandom);
            shift_out  = WIDTH'($urandom);
            arith_flag = ($urandom_range(0, 4) == 0);
            logic_flag = ($urandom_range(0, 4) == 0);
            cmp_flag   = ($urandom_range(0, 4) == 0);
            shift_flag = ($urandom_range(0, 4) == 0);
            tx_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        clear_flags();
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, ALU result width; a multiple of 8 in the range 8..64.
REQ-002 The block SHALL have parameter DEPTH, default 4, result FIFO depth in words; a power of 2, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports arith_out, logic_out, cmp_out and shift_out, inputs, WIDTH bits each: registered ALU unit results.
REQ-006 The block SHALL have ports arith_flag, logic_flag, cmp_flag and shift_flag, inputs, 1 bit each: result-valid pulses, one per unit.
REQ-007 The block SHALL have port tx_data, output, 8 bits: byte toward the UART transmitter.
REQ-008 The block SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 The block SHALL have port tx_ready, input, 1 bit: the transmitter accepts a byte.
REQ-010 The block SHALL have port busy, output, 1 bit: FIFO non-empty or serialization in progress.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, a result was dropped.
REQ-012 The block SHALL have port multi_flag_err, output, 1 bit: sticky flag, two or more result flags were high in the same cycle.

Function
REQ-013 On each rising clk edge with any flag high, the block SHALL select the result of the highest-priority flagged unit (arith > logic > cmp > shift) and push it into the FIFO.
REQ-014 When two or more flags are high in one cycle, the block SHALL push exactly one word (the priority winner) and set multi_flag_err.
REQ-015 When a push is requested, the FIFO is full and no pop occurs in that cycle, the block SHALL drop the word, set overflow and leave the FIFO contents unchanged.
REQ-016 When the FIFO is full and a push and a pop occur in the same cycle, the block SHALL accept the push and SHALL NOT set overflow.
REQ-017 FIFO read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and the remaining bits are equal; empty = pointers equal.
REQ-018 The FSM SHALL have states IDLE and SEND.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the head word into a WIDTH-bit shift register, clear the byte counter and enter SEND.
REQ-020 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal shift register bits [7:0].
REQ-021 In SEND, on a cycle with tx_valid and tx_ready both high, the block SHALL shift the register right by 8 and increment the byte counter.
REQ-022 In SEND, when the last byte (counter = WIDTH/8-1) is accepted, the FSM SHALL return to IDLE; there is no back-to-back pop in that same cycle.
REQ-023 In SEND with tx_ready low, tx_data and tx_valid SHALL hold stable; tx_valid SHALL NOT drop before the handshake completes.
REQ-024 In IDLE, tx_valid SHALL be 0.
REQ-025 Byte order SHALL be least-significant byte first.
REQ-026 Latency: for a flag sampled at edge N into an empty FIFO with the FSM in IDLE, pop SHALL occur at edge N+1 and tx_valid SHALL be high in the cycle after edge N+1.
REQ-027 Throughput: one word SHALL take WIDTH/8 accepted bytes plus 1 IDLE cycle.
REQ-028 overflow and multi_flag_err SHALL clear only on reset.

Reset
REQ-029 While rst is low, the block SHALL asynchronously set FIFO pointers to 0, the FSM to IDLE, the shift register and byte counter to 0, tx_data = 0x00, tx_valid = 0, busy = 0, overflow = 0 and multi_flag_err = 0.
REQ-030 Reset asserted mid-SEND SHALL abort the word and discard all queued FIFO words; no partial byte SHALL be re-sent after reset release.
REQ-031 The FIFO storage array SHALL NOT be reset.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE = 1'b0, SEND = 1'b1) and the flag priority order.
REQ-033 The FIFO SHALL be the sub-module result_fifo, parameterized by WIDTH and DEPTH, with push, pop, full and empty ports.
REQ-034 The priority select and the serializer FSM SHALL stay in the top module.

Verification
REQ-035 Bench SHALL drive arith_flag=1 with arith_out=0xBEEF, tx_ready held 1, and check bytes 0xEF then 0xBE on consecutive cycles, tx_valid first high per REQ-026, busy low afterwards.
REQ-036 Bench SHALL drive logic_flag=1 and shift_flag=1 in the same cycle with logic_out=0x00F0 and shift_out=0x1234, and check that only 0x00F0 is sent and multi_flag_err=1.
REQ-037 Bench SHALL hold tx_ready=0 and push 6 words (DEPTH=4), and check that the first word is latched in the shift register, 4 words are queued, the 6th is dropped, overflow=1, and 5 words are delivered in order after tx_ready=1.
REQ-038 Bench SHALL toggle tx_ready 1,0,0,1 during SEND of 0xA55A, and check that tx_data holds 0x5A while stalled, then sends 0xA5, with no duplicated or lost bytes.
REQ-039 Bench SHALL assert rst low after the first byte of 0x1357 has been accepted, with 2 words queued, and check tx_valid=0 immediately and no output after release until a new flag arrives.
REQ-040 Bench SHALL, with the FIFO full and the FSM in IDLE, push in the pop cycle, and check the word is accepted and overflow stays 0.
